// File: rtl/ikaopll_pkg.sv
// Shared constants, patch field layout and preset ROM for the OPLL parameter sequencer.
// The ROM is only consumed when IKAOPLL_ROMPATCH_EN is defined.
package ikaopll_pkg;

   localparam int NUM_SLOT = 18;

   localparam logic [7:0] USR_BASE  = 8'h00;
   localparam logic [7:0] FNUM_BASE = 8'h10;
   localparam logic [7:0] CTRL_BASE = 8'h20;
   localparam logic [7:0] INST_BASE = 8'h30;

   typedef struct packed {
      logic       am;
      logic       vib;
      logic       egt;
      logic       ksr;
      logic [3:0] mult;
      logic [3:0] ar;
      logic [3:0] dr;
      logic [3:0] sl;
      logic [3:0] rr;
   } patch_half_t;

   // byte 0 in [63:56] ... byte 7 in [7:0]
   localparam logic [63:0] ROM_PATCH [1:15] = '{
      64'h71611E17D0780017,
      64'h13411A0DD8F72313,
      64'h13019900F2C42123,
      64'h11610E078D647027,
      64'h32211E06E1760128,
      64'h31221605E0710018,
      64'h21611D0782811107,
      64'h33212D13B0700007,
      64'h61611B0664651017,
      64'h41610B1885F08107,
      64'h33018311EAEF1004,
      64'h17C12407F8F82212,
      64'h61500C05D2F54042,
      64'h01015503E9900302,
      64'h41418903F1E40313
   };

   function automatic logic [7:0] f_rom_byte(input logic [3:0] inst,
                                             input logic [2:0] idx);
      logic [63:0] p;
      p = ROM_PATCH[inst];
      return p[{~idx, 3'b000} +: 8];
   endfunction

   function automatic patch_half_t f_half(input logic [7:0] b0,
                                          input logic [7:0] b4,
                                          input logic [7:0] b6);
      patch_half_t ph;
      ph.am   = b0[7];
      ph.vib  = b0[6];
      ph.egt  = b0[5];
      ph.ksr  = b0[4];
      ph.mult = b0[3:0];
      ph.ar   = b4[7:4];
      ph.dr   = b4[3:0];
      ph.sl   = b6[7:4];
      ph.rr   = b6[3:0];
      return ph;
   endfunction

endpackage

// File: rtl/ikaopll_busif.sv
// CPU bus sampler: WR rising-edge detect while selected, address latch,
// and a same-edge data write strobe toward the register file.
module ikaopll_busif (
   input  logic       i_EMUCLK,
   input  logic       i_IC_n,
   input  logic       i_phiM_PCEN_n,
   input  logic       i_CS_n,
   input  logic       i_WR_n,
   input  logic       i_A0,
   input  logic [7:0] i_D,
   output logic       o_wr_stb,
   output logic [7:0] o_addr,
   output logic [7:0] o_data
);

   logic       r_cs_n;
   logic       r_wr_n;
   logic [7:0] r_addr;
   logic       w_edge;

   assign w_edge   = ~i_phiM_PCEN_n & ~r_cs_n & ~r_wr_n & i_WR_n;
   assign o_wr_stb = w_edge & i_A0;
   assign o_addr   = r_addr;
   assign o_data   = i_D;

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         r_cs_n <= 1'b0;
         r_wr_n <= 1'b0;
         r_addr <= 8'h00;
      end else if (!i_phiM_PCEN_n) begin
         r_cs_n <= i_CS_n;
         r_wr_n <= i_WR_n;
         if (w_edge && !i_A0) r_addr <= i_D;
      end
   end

endmodule

// File: rtl/ikaopll_op_param_seq.sv
// Register file and 18-slot parameter sequencer feeding the EG/PG.
// Define IKAOPLL_ROMPATCH_EN to enable preset-ROM instrument selection.
import ikaopll_pkg::*;

module ikaopll_op_param_seq #(
   parameter int NUM_CH = 9
) (
   input  logic       i_EMUCLK,
   input  logic       i_IC_n,
   input  logic       i_phiM_PCEN_n,
   input  logic       i_phi1_NCEN_n,
   input  logic       i_CS_n,
   input  logic       i_WR_n,
   input  logic       i_A0,
   input  logic [7:0] i_D,
   output logic       o_CYCLE_00,
   output logic       o_CYCLE_17,
   output logic       o_MnC_SEL,
   output logic [8:0] o_FNUM,
   output logic [2:0] o_BLOCK,
   output logic       o_KON,
   output logic       o_SUSEN,
   output logic       o_ETYP,
   output logic       o_KSR,
   output logic [3:0] o_AR,
   output logic [3:0] o_DR,
   output logic [3:0] o_RR,
   output logic [3:0] o_SL,
   output logic [3:0] o_VOL
);

   localparam logic [3:0] LP_CH   = 4'(NUM_CH);
   localparam logic [4:0] LP_LAST = 5'(2 * NUM_CH - 1);

   logic       w_wr_stb;
   logic [7:0] w_addr;
   logic [7:0] w_data;

   logic [7:0] r_usr  [8];
   logic [7:0] r_fnum [NUM_CH];
   logic [5:0] r_ctrl [NUM_CH];
   logic [7:0] r_inst [NUM_CH];
   logic [4:0] r_cnt;

   logic [3:0]  w_ch;
   logic        w_mnc;
   logic [3:0]  w_inst;
   logic [7:0]  w_b0, w_b4, w_b6;
   patch_half_t w_ph;
   logic        w_unused;

   ikaopll_busif u_busif (
      .i_EMUCLK      (i_EMUCLK),
      .i_IC_n        (i_IC_n),
      .i_phiM_PCEN_n (i_phiM_PCEN_n),
      .i_CS_n        (i_CS_n),
      .i_WR_n        (i_WR_n),
      .i_A0          (i_A0),
      .i_D           (i_D),
      .o_wr_stb      (w_wr_stb),
      .o_addr        (w_addr),
      .o_data        (w_data)
   );

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         for (int i = 0; i < 8; i++) r_usr[i] <= 8'h00;
         for (int i = 0; i < NUM_CH; i++) begin
            r_fnum[i] <= 8'h00;
            r_ctrl[i] <= 6'h00;
            r_inst[i] <= 8'h00;
         end
      end else if (w_wr_stb) begin
         if (w_addr[7:3] == USR_BASE[7:3])
            r_usr[w_addr[2:0]] <= w_data;
         else if (w_addr[3:0] < LP_CH) begin
            if (w_addr[7:4] == FNUM_BASE[7:4])
               r_fnum[w_addr[3:0]] <= w_data;
            else if (w_addr[7:4] == CTRL_BASE[7:4])
               r_ctrl[w_addr[3:0]] <= w_data[5:0];
            else if (w_addr[7:4] == INST_BASE[7:4])
               r_inst[w_addr[3:0]] <= w_data;
         end
      end
   end

   assign w_ch   = r_cnt[4:1];
   assign w_mnc  = r_cnt[0];
   assign w_inst = r_inst[w_ch][7:4];

   // modulator uses even user bytes, carrier the odd ones
   always_comb begin
      w_b0 = r_usr[{2'b00, w_mnc}];
      w_b4 = r_usr[{2'b10, w_mnc}];
      w_b6 = r_usr[{2'b11, w_mnc}];
`ifdef IKAOPLL_ROMPATCH_EN
      if (w_inst != 4'd0) begin
         w_b0 = f_rom_byte(w_inst, {2'b00, w_mnc});
         w_b4 = f_rom_byte(w_inst, {2'b10, w_mnc});
         w_b6 = f_rom_byte(w_inst, {2'b11, w_mnc});
      end
`endif
   end

   assign w_ph     = f_half(w_b0, w_b4, w_b6);
   assign w_unused = ^{w_ph.am, w_ph.vib, w_ph.mult, w_inst};

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         r_cnt      <= 5'd0;
         o_CYCLE_00 <= 1'b0;
         o_CYCLE_17 <= 1'b0;
         o_MnC_SEL  <= 1'b0;
         o_FNUM     <= 9'd0;
         o_BLOCK    <= 3'd0;
         o_KON      <= 1'b0;
         o_SUSEN    <= 1'b0;
         o_ETYP     <= 1'b0;
         o_KSR      <= 1'b0;
         o_AR       <= 4'd0;
         o_DR       <= 4'd0;
         o_RR       <= 4'd0;
         o_SL       <= 4'd0;
         o_VOL      <= 4'd0;
      end else if (!i_phi1_NCEN_n) begin
         r_cnt      <= (r_cnt == LP_LAST) ? 5'd0 : r_cnt + 5'd1;
         o_CYCLE_00 <= (r_cnt == 5'd0);
         o_CYCLE_17 <= (r_cnt == LP_LAST);
         o_MnC_SEL  <= w_mnc;
         o_FNUM     <= {r_ctrl[w_ch][0], r_fnum[w_ch]};
         o_BLOCK    <= r_ctrl[w_ch][3:1];
         o_KON      <= r_ctrl[w_ch][4];
         o_SUSEN    <= r_ctrl[w_ch][5];
         o_ETYP     <= w_ph.egt;
         o_KSR      <= w_ph.ksr;
         o_AR       <= w_ph.ar;
         o_DR       <= w_ph.dr;
         o_RR       <= w_ph.rr;
         o_SL       <= w_ph.sl;
         o_VOL      <= w_mnc ? r_inst[w_ch][3:0] : 4'd0;
      end
   end

endmodule
